// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: valid tracking, load-use stall, branch flush, halt/drain/restart FSM.
// Outputs are combinational from registered state; PIPE_CTRL_PERF_EN adds stall/flush counters.
module pipe_ctrl #(
   parameter logic [7:0] HALT_OP = 8'hFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  insIFID,
   input  logic [7:0]  insIDEX,
   input  logic        brTakenEX,
   input  logic        start,
   output logic        pcWe,
   output logic        ifidWe,
   output logic        ifidClr,
   output logic        idexClr,
   output logic        weWB,
   output logic        halted,
   output logic [1:0]  state
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [15:0] stallCnt,
   output logic [15:0] flushCnt
`endif
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_DRAIN  = 2'b01,
      ST_HALTED = 2'b10
   } state_t;

   state_t     state_q, state_d;
   logic       validIFID_q, validIFID_d;
   logic       validIDEX_q, validIDEX_d;
   logic       validWB_q, validWB_d;
   logic [7:0] insWB_q, insWB_d;

   logic       hazard;
   logic       flush;
   logic       halt_req;
   logic [2:0] ld_dst;

   assign ld_dst = insIDEX[5:3];

   // Only loads produce a result too late for WB-to-EX forwarding.
   assign hazard = validIFID_q && validIDEX_q && (insIDEX[7:6] == 2'b10) &&
                   (((insIFID[7:6] == 2'b01) && ((insIFID[5:3] == ld_dst) || (insIFID[2:0] == ld_dst))) ||
                    ((insIFID[7:6] == 2'b10) && (insIFID[2:0] == ld_dst)));

   assign flush    = (state_q == ST_RUN) && brTakenEX && validIDEX_q;
   assign halt_req = (state_q == ST_RUN) && validIFID_q && (insIFID == HALT_OP);

   always_comb begin
      state_d = state_q;
      pcWe    = 1'b1;
      ifidWe  = 1'b1;
      ifidClr = 1'b0;
      idexClr = 1'b0;
      halted  = 1'b0;
      weWB    = ~(validWB_q && (insWB_q[7:6] != 2'b11));
      case (state_q)
         ST_RUN: begin
            if (flush) begin
               ifidClr = 1'b1;
               idexClr = 1'b1;
            end else if (halt_req) begin
               pcWe    = 1'b0;
               ifidWe  = 1'b0;
               idexClr = 1'b1;
               state_d = ST_DRAIN;
            end else if (hazard) begin
               pcWe    = 1'b0;
               ifidWe  = 1'b0;
               idexClr = 1'b1;
            end
         end
         ST_DRAIN: begin
            pcWe    = 1'b0;
            ifidWe  = 1'b0;
            idexClr = 1'b1;
            if (!validIDEX_q && !validWB_q) begin
               state_d = ST_HALTED;
            end
         end
         ST_HALTED: begin
            pcWe   = 1'b0;
            ifidWe = 1'b0;
            weWB   = 1'b1;
            halted = 1'b1;
            if (start) begin
               ifidClr = 1'b1;
               pcWe    = 1'b1;
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      validIFID_d = ifidClr ? 1'b0 : (ifidWe ? (state_q == ST_RUN) : validIFID_q);
      validIDEX_d = idexClr ? 1'b0 : validIFID_q;
      validWB_d   = validIDEX_q;
      insWB_d     = insIDEX;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         validIFID_q <= 1'b0;
         validIDEX_q <= 1'b0;
         validWB_q   <= 1'b0;
         insWB_q     <= 8'h00;
      end else begin
         state_q     <= state_d;
         validIFID_q <= validIFID_d;
         validIDEX_q <= validIDEX_d;
         validWB_q   <= validWB_d;
         insWB_q     <= insWB_d;
      end
   end

   assign state = state_q;

`ifdef PIPE_CTRL_PERF_EN
   logic        stall_evt;
   logic [15:0] stallCnt_q, stallCnt_d;
   logic [15:0] flushCnt_q, flushCnt_d;

   assign stall_evt = (state_q == ST_RUN) && !flush && !halt_req && hazard;

   always_comb begin
      stallCnt_d = stallCnt_q;
      flushCnt_d = flushCnt_q;
      if (stall_evt && (stallCnt_q != 16'hFFFF)) stallCnt_d = stallCnt_q + 16'd1;
      if (flush && (flushCnt_q != 16'hFFFF))     flushCnt_d = flushCnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stallCnt_q <= 16'h0000;
         flushCnt_q <= 16'h0000;
      end else begin
         stallCnt_q <= stallCnt_d;
         flushCnt_q <= flushCnt_d;
      end
   end

   assign stallCnt = stallCnt_q;
   assign flushCnt = flushCnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, load-use stall, branch flush, halt/drain/restart, reset in DRAIN.
module tb_pipe_ctrl;
   logic       clk;
   logic       rst;
   logic [7:0] insIFID;
   logic [7:0] insIDEX;
   logic       brTakenEX;
   logic       start;
   logic       pcWe, ifidWe, ifidClr, idexClr, weWB, halted;
   logic [1:0] state;
`ifdef PIPE_CTRL_PERF_EN
   logic [15:0] stallCnt, flushCnt;
`endif

   int total  = 0;
   int passed = 0;

   pipe_ctrl #(.HALT_OP(8'hFF)) dut (
      .clk(clk), .rst(rst), .insIFID(insIFID), .insIDEX(insIDEX),
      .brTakenEX(brTakenEX), .start(start),
      .pcWe(pcWe), .ifidWe(ifidWe), .ifidClr(ifidClr), .idexClr(idexClr),
      .weWB(weWB), .halted(halted), .state(state)
`ifdef PIPE_CTRL_PERF_EN
      , .stallCnt(stallCnt), .flushCnt(flushCnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   localparam logic [7:0] LD_R3   = 8'b10_011_000;
   localparam logic [7:0] ALU_R3  = 8'b01_001_011;
   localparam logic [7:0] ALU_R2  = 8'b01_001_010;
   localparam logic [7:0] BRANCH  = 8'hC0;
   localparam logic [7:0] HALT    = 8'hFF;

   initial begin
      rst = 1'b1; insIFID = 8'h00; insIDEX = 8'h00; brTakenEX = 1'b0; start = 1'b0;
      tick(); tick();
      #1;
      chk("rst_state", 16'(state), 16'h0);
      chk("rst_pcWe", 16'(pcWe), 16'h1);
      chk("rst_ifidWe", 16'(ifidWe), 16'h1);
      chk("rst_ifidClr", 16'(ifidClr), 16'h0);
      chk("rst_idexClr", 16'(idexClr), 16'h0);
      chk("rst_weWB", 16'(weWB), 16'h1);
      chk("rst_halted", 16'(halted), 16'h0);
`ifdef PIPE_CTRL_PERF_EN
      chk("rst_stallCnt", stallCnt, 16'h0);
      chk("rst_flushCnt", flushCnt, 16'h0);
`endif
      rst = 1'b0;

      // Bubbles filling the pipe: no WB write until a valid instruction reaches WB.
      tick(); #1;
      chk("fill1_weWB", 16'(weWB), 16'h1);
      chk("fill1_pcWe", 16'(pcWe), 16'h1);
      tick(); #1;
      chk("fill2_weWB", 16'(weWB), 16'h1);
      tick(); #1;
      chk("fill3_weWB", 16'(weWB), 16'h0);

      // Load r3 in EX, ALU reading r3 in ID: one stall cycle.
      insIDEX = LD_R3; insIFID = ALU_R3; #1;
      chk("haz_pcWe", 16'(pcWe), 16'h0);
      chk("haz_ifidWe", 16'(ifidWe), 16'h0);
      chk("haz_idexClr", 16'(idexClr), 16'h1);
      chk("haz_ifidClr", 16'(ifidClr), 16'h0);
      tick();
      insIDEX = 8'h00; #1;
      chk("post_haz_pcWe", 16'(pcWe), 16'h1);
      chk("post_haz_ifidWe", 16'(ifidWe), 16'h1);
      chk("post_haz_idexClr", 16'(idexClr), 16'h0);
      chk("load_in_wb_weWB", 16'(weWB), 16'h0);
`ifdef PIPE_CTRL_PERF_EN
      chk("stallCnt_1", stallCnt, 16'h1);
`endif
      tick(); #1;
      chk("bubble_wb_weWB", 16'(weWB), 16'h1);

      // Dependency variants with load r3 in EX.
      insIDEX = LD_R3; insIFID = ALU_R2; #1;
      chk("alu_r2_nostall", 16'(pcWe), 16'h1);
      insIFID = 8'b10_000_011; #1;
      chk("load_src_r3_stall", 16'(idexClr), 16'h1);
      insIFID = 8'b10_011_000; #1;
      chk("load_dst_r3_nostall", 16'(pcWe), 16'h1);
      insIFID = 8'b01_011_000; #1;
      chk("alu_dst_r3_stall", 16'(pcWe), 16'h0);
      insIDEX = 8'b01_011_000; insIFID = ALU_R3; #1;
      chk("alu_in_ex_nostall", 16'(pcWe), 16'h1);
      insIDEX = LD_R3; insIFID = ALU_R2;
      tick();

      // Flush coinciding with a hazard: flush wins.
      insIFID = ALU_R3; brTakenEX = 1'b1; #1;
      chk("flush_haz_pcWe", 16'(pcWe), 16'h1);
      chk("flush_haz_ifidClr", 16'(ifidClr), 16'h1);
      insIDEX = BRANCH; insIFID = ALU_R2; #1;
      chk("br_ifidClr", 16'(ifidClr), 16'h1);
      chk("br_idexClr", 16'(idexClr), 16'h1);
      chk("br_pcWe", 16'(pcWe), 16'h1);
      tick();
      insIDEX = LD_R3; insIFID = ALU_R3; #1;
      chk("br_wb_nowrite", 16'(weWB), 16'h1);
      chk("br_idex_invalid", 16'(ifidClr), 16'h0);
      chk("br_ifid_invalid", 16'(pcWe), 16'h1);
      brTakenEX = 1'b0; insIDEX = 8'h00; insIFID = 8'h00;
      tick(); #1;
      chk("br_bubble_weWB", 16'(weWB), 16'h1);
`ifdef PIPE_CTRL_PERF_EN
      chk("flushCnt_1", flushCnt, 16'h1);
      chk("stallCnt_still1", stallCnt, 16'h1);
`endif
      tick();

      // Halt in ID together with a taken branch: halt discarded.
      insIFID = HALT; insIDEX = BRANCH; brTakenEX = 1'b1; #1;
      chk("halt_flush_pcWe", 16'(pcWe), 16'h1);
      chk("halt_flush_ifidClr", 16'(ifidClr), 16'h1);
      tick();
      brTakenEX = 1'b0; insIDEX = 8'h00; #1;
      chk("halt_flush_state", 16'(state), 16'h0);
      chk("halt_flush_no_drain", 16'(pcWe), 16'h1);
      insIFID = 8'h00;
      tick(); tick();

      // Halt: DRAIN then HALTED.
      insIFID = HALT; #1;
      chk("halt_pcWe", 16'(pcWe), 16'h0);
      chk("halt_ifidWe", 16'(ifidWe), 16'h0);
      chk("halt_idexClr", 16'(idexClr), 16'h1);
      tick();
      start = 1'b1; #1;
      chk("drain_state", 16'(state), 16'h1);
      chk("drain_pcWe", 16'(pcWe), 16'h0);
      chk("drain_weWB", 16'(weWB), 16'h0);
      chk("drain_start_ignored", 16'(ifidClr), 16'h0);
      start = 1'b0;
      tick(); #1;
      chk("drain2_state", 16'(state), 16'h1);
      tick(); #1;
      chk("halted_state", 16'(state), 16'h2);
      chk("halted_flag", 16'(halted), 16'h1);
      chk("halted_pcWe", 16'(pcWe), 16'h0);
      chk("halted_idexClr", 16'(idexClr), 16'h0);
      chk("halted_weWB", 16'(weWB), 16'h1);
      tick(); #1;
      chk("halted_stays", 16'(state), 16'h2);
      start = 1'b1; #1;
      chk("start_ifidClr", 16'(ifidClr), 16'h1);
      chk("start_pcWe", 16'(pcWe), 16'h1);
      tick();
      start = 1'b0; #1;
      chk("restart_state", 16'(state), 16'h0);
      chk("restart_halted", 16'(halted), 16'h0);
      chk("restart_ifid_invalid", 16'(pcWe), 16'h1);
      tick(); #1;
      chk("restart_ifid_valid", 16'(pcWe), 16'h0);

      // Reset asserted during DRAIN.
      tick(); #1;
      chk("drain_again", 16'(state), 16'h1);
`ifdef PIPE_CTRL_PERF_EN
      chk("flushCnt_2", flushCnt, 16'h2);
`endif
      rst = 1'b1;
      tick();
      brTakenEX = 1'b1; #1;
      chk("rst_drain_state", 16'(state), 16'h0);
      chk("rst_drain_weWB", 16'(weWB), 16'h1);
      chk("rst_drain_pcWe", 16'(pcWe), 16'h1);
      chk("rst_drain_ifidWe", 16'(ifidWe), 16'h1);
      chk("rst_drain_idex_invalid", 16'(ifidClr), 16'h0);
`ifdef PIPE_CTRL_PERF_EN
      chk("rst_drain_stallCnt", stallCnt, 16'h0);
      chk("rst_drain_flushCnt", flushCnt, 16'h0);
`endif
      brTakenEX = 1'b0; rst = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
